// File: rtl/fp_inv_sqrt_iter_pkg.sv
// Shared types, constants and fixed-point helpers for the folded inverse square root unit.
package fp_inv_sqrt_iter_pkg;

  localparam int unsigned FP_MAX_W = 64;
  localparam int unsigned FP_WIDTH = 32;
  localparam int unsigned FP_FRAC  = 16;

  typedef logic signed [FP_WIDTH-1:0] fp_word_t;
  typedef logic signed [FP_MAX_W-1:0] fp_wide_t;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    IT_XY,
    IT_TY,
    IT_UPD,
    DONE
  } state_e;

  function automatic fp_wide_t FP_THREE(input int unsigned frac);
    return fp_wide_t'(3) << frac;
  endfunction

  function automatic fp_wide_t FP_MAX_POS(input int unsigned width);
    return (fp_wide_t'(1) << (width - 1)) - fp_wide_t'(1);
  endfunction

  function automatic real fp_to_real(input fp_wide_t v, input int unsigned frac);
    return real'(v) / (2.0 ** frac);
  endfunction

  function automatic fp_wide_t fp_from_real(input real r, input int unsigned frac);
    return fp_wide_t'(longint'(r * (2.0 ** frac)));
  endfunction

endpackage

// File: rtl/fp_inv_sqrt_iter_if.sv
// Request/result handshake bundle between the normaliser and the inverse square root unit.
interface fp_inv_sqrt_iter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) ();

  logic signed [WIDTH-1:0] a_in;
  logic [TAG_W-1:0]        tag_in;
  logic                    valid_in;
  logic                    ready_out;
  logic signed [WIDTH-1:0] res_out;
  logic [TAG_W-1:0]        tag_out;
  logic                    err_out;
  logic                    valid_out;
  logic                    ready_in;

  modport master (
    output a_in, tag_in, valid_in, ready_in,
    input  ready_out, res_out, tag_out, err_out, valid_out
  );

  modport slave (
    input  a_in, tag_in, valid_in, ready_in,
    output ready_out, res_out, tag_out, err_out, valid_out
  );

endinterface

// File: rtl/fp_inv_sqrt_seed.sv
// Combinational Newton seed: leading-one detect and power-of-two exponent halving.
// FP_INV_SQRT_LUT_SEED_EN adds a 16-entry mantissa correction ROM.
module fp_inv_sqrt_seed #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  output logic signed [WIDTH-1:0] y0_o
);

  localparam int unsigned LW = $clog2(WIDTH);

  logic [LW-1:0]    lead;
  logic [WIDTH-1:0] pow2;
  int               exp_e;
  int               half_e;
  int               sh;

  // Exponent of the leading one, halved with ceiling so y0*sqrt(a) stays in [0.707, 1.414)
  always_comb begin
    lead = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (a_i[i]) lead = LW'(i);
    end
    exp_e  = int'(lead) - int'(FRAC);
    half_e = (exp_e + 1) >>> 1;
    sh     = int'(FRAC) - half_e;
    pow2   = WIDTH'(1) << sh;
  end

`ifdef FP_INV_SQRT_LUT_SEED_EN
  localparam int unsigned EXT_W = WIDTH + 16;

  // Factors in Q1.15: geometric-mean 1/sqrt(m) per eighth of [1,2), upper half scaled by sqrt(2)
  function automatic logic [15:0] rom_factor(input logic [3:0] idx);
    logic [15:0] f;
    case (idx)
      4'h0:    f = 16'd31817;
      4'h1:    f = 16'd30091;
      4'h2:    f = 16'd28619;
      4'h3:    f = 16'd27344;
      4'h4:    f = 16'd26225;
      4'h5:    f = 16'd25233;
      4'h6:    f = 16'd24347;
      4'h7:    f = 16'd23548;
      4'h8:    f = 16'd44996;
      4'h9:    f = 16'd42555;
      4'hA:    f = 16'd40473;
      4'hB:    f = 16'd38670;
      4'hC:    f = 16'd37088;
      4'hD:    f = 16'd35685;
      4'hE:    f = 16'd34431;
      default: f = 16'd33302;
    endcase
    return f;
  endfunction

  logic [WIDTH-1:0] norm;
  logic [2:0]       mant;
  logic [EXT_W-1:0] scaled;

  always_comb begin
    norm   = a_i << (LW'(WIDTH - 1) - lead);
    mant   = 3'(norm >> (WIDTH - 4));
    scaled = EXT_W'(pow2) * EXT_W'(rom_factor({exp_e[0], mant}));
    y0_o   = WIDTH'(scaled >> 15);
  end
`else
  assign y0_o = pow2;
`endif

endmodule

// File: rtl/fp_inv_sqrt_iter.sv
// Folded fixed-point 1/sqrt(a) by Newton-Raphson with one shared multiplier.
// Optional ROM seed refinement via FP_INV_SQRT_LUT_SEED_EN (see fp_inv_sqrt_seed).
module fp_inv_sqrt_iter
  import fp_inv_sqrt_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned ITERS = 4,
  parameter int unsigned TAG_W = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  fp_inv_sqrt_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef logic signed [WIDTH-1:0] word_t;

  localparam word_t THREE   = WIDTH'(FP_THREE(FRAC));
  localparam word_t MAX_POS = WIDTH'(FP_MAX_POS(WIDTH));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  word_t              a_q, a_d;
  word_t              y_q, y_d;
  word_t              t_q, t_d;
  logic [TAG_W-1:0]   tagc_q, tagc_d;
  word_t              res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  word_t              seed;
  word_t              mul_a, mul_b, mul_res;
  logic signed [PW-1:0] prod;

  fp_inv_sqrt_seed #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_seed (
    .a_i  (a_q),
    .y0_o (seed)
  );

  // Shared multiplier: operand B selected by the iteration phase
  always_comb begin
    mul_a = y_q;
    mul_b = a_q;
    case (state_q)
      IT_TY:   mul_b = t_q;
      IT_UPD:  mul_b = THREE - t_q;
      default: mul_b = a_q;
    endcase
    prod    = PW'(mul_a) * PW'(mul_b);
    mul_res = WIDTH'(prod >>> FRAC);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    y_d     = y_q;
    t_d     = t_q;
    tagc_d  = tagc_q;
    res_d   = res_q;
    tag_d   = tag_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in && ready_q) begin
          a_d     = bus.a_in;
          tagc_d  = bus.tag_in;
          state_d = SEED;
        end
      end
      SEED: begin
        cnt_d = '0;
        if (!a_q[WIDTH-1] && (a_q != '0)) begin
          y_d     = seed;
          state_d = IT_XY;
        end else begin
          res_d   = MAX_POS;
          err_d   = 1'b1;
          tag_d   = tagc_q;
          state_d = DONE;
        end
      end
      IT_XY: begin
        t_d     = mul_res;
        state_d = IT_TY;
      end
      IT_TY: begin
        t_d     = mul_res;
        state_d = IT_UPD;
      end
      IT_UPD: begin
        y_d   = mul_res >>> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          res_d   = y_d;
          err_d   = 1'b0;
          tag_d   = tagc_q;
          state_d = DONE;
        end else begin
          state_d = IT_XY;
        end
      end
      DONE: begin
        if (valid_q && bus.ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      tagc_q  <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      y_q     <= y_d;
      t_q     <= t_d;
      tagc_q  <= tagc_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.res_out   = res_q;
  assign bus.tag_out   = tag_q;
  assign bus.err_out   = err_q;

endmodule

// File: tb/tb_fp_inv_sqrt_iter.sv
// Directed self-checking bench for fp_inv_sqrt_iter (default build, or FP_INV_SQRT_LUT_SEED_EN build).
module tb_fp_inv_sqrt_iter;
  import fp_inv_sqrt_iter_pkg::*;

`ifdef FP_INV_SQRT_LUT_SEED_EN
  localparam int unsigned W  = 24;
  localparam int unsigned F  = 12;
  localparam int unsigned I  = 2;
  localparam int          LAT_OK  = 8;
  localparam logic [63:0] ERR_RES = 64'h7FFFFF;
`else
  localparam int unsigned W  = 32;
  localparam int unsigned F  = 16;
  localparam int unsigned I  = 4;
  localparam int          LAT_OK  = 14;
  localparam logic [63:0] ERR_RES = 64'h7FFFFFFF;
`endif
  localparam int unsigned TW = 4;
  localparam int          LAT_ERR = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fp_inv_sqrt_iter_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  fp_inv_sqrt_iter #(
    .WIDTH (W),
    .FRAC  (F),
    .ITERS (I),
    .TAG_W (TW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp, input real tol);
    checks++;
    assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
      failures++;
      $error("FAIL %s observed=%f expected=%f tol=%f", tag, obs, exp, tol);
    end
  endtask

  function automatic real res_real();
    return fp_to_real(fp_wide_t'(bus.res_out), F);
  endfunction

  // Issue one request and return edges from accept (inclusive) to first valid_out cycle
  task automatic run_req(input real a, input logic [TW-1:0] tag, output int lat);
    int n;
    n = 0;
    while (!bus.ready_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.a_in     = W'(fp_from_real(a, F));
    bus.tag_in   = tag;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_res;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.a_in     = '0;
    bus.tag_in   = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", 64'(bus.ready_out), 64'd1);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_err",   64'(bus.err_out),   64'd0);
    chk("rst_res",   64'(bus.res_out),   64'd0);
    chk("rst_tag",   64'(bus.tag_out),   64'd0);

`ifdef FP_INV_SQRT_LUT_SEED_EN
    run_req(5.8, 4'd6, lat);
    chk("lut_lat", 64'(lat), 64'(LAT_OK));
    chk_real("lut_5p8", res_real(), 0.415227, 1e-3);
    chk("lut_err", 64'(bus.err_out), 64'd0);
    chk("lut_tag", 64'(bus.tag_out), 64'd6);
    retire();

    run_req(1.0, 4'd2, lat);
    chk_real("lut_1p0", res_real(), 1.0, 1e-3);
    retire();

    run_req(0.0, 4'd8, lat);
    chk("lut_zero_lat", 64'(lat), 64'(LAT_ERR));
    chk("lut_zero_err", 64'(bus.err_out), 64'd1);
    chk("lut_zero_res", 64'(bus.res_out), ERR_RES);
    retire();
`else
    run_req(0.5, 4'd1, lat);
    chk("lat_0p5", 64'(lat), 64'(LAT_OK));
    chk_real("res_0p5", res_real(), 1.414214, 1e-4);
    chk("err_0p5", 64'(bus.err_out), 64'd0);
    chk("tag_0p5", 64'(bus.tag_out), 64'd1);
    retire();
    chk("ready_after_retire", 64'(bus.ready_out), 64'd1);

    run_req(1.0, 4'd2, lat);
    chk("lat_1p0", 64'(lat), 64'(LAT_OK));
    chk_real("res_1p0", res_real(), 1.0, 1e-4);
    chk("tag_1p0", 64'(bus.tag_out), 64'd2);
    retire();

    run_req(3.7, 4'd3, lat);
    chk("lat_3p7", 64'(lat), 64'(LAT_OK));
    chk_real("res_3p7", res_real(), 0.519875, 1e-4);
    chk("err_3p7", 64'(bus.err_out), 64'd0);
    retire();

    run_req(6.9, 4'd4, lat);
    chk("lat_6p9", 64'(lat), 64'(LAT_OK));
    chk_real("res_6p9", res_real(), 0.380693, 1e-4);
    chk("tag_6p9", 64'(bus.tag_out), 64'd4);
    retire();

    run_req(1.0 / 65536.0, 4'd5, lat);
    chk_real("res_min", res_real(), 256.0, 256.0 * 1e-4);
    chk("lat_min", 64'(lat), 64'(LAT_OK));
    retire();

    run_req(16384.0, 4'd6, lat);
    chk_real("res_big", res_real(), 0.0078125, 0.0078125 * 1e-4);
    retire();

    run_req(0.0, 4'd7, lat);
    chk("lat_zero", 64'(lat), 64'(LAT_ERR));
    chk("err_zero", 64'(bus.err_out), 64'd1);
    chk("res_zero", 64'(bus.res_out), ERR_RES);
    chk("tag_zero", 64'(bus.tag_out), 64'd7);
    retire();

    run_req(-2.5, 4'd8, lat);
    chk("lat_neg", 64'(lat), 64'(LAT_ERR));
    chk("err_neg", 64'(bus.err_out), 64'd1);
    chk("res_neg", 64'(bus.res_out), ERR_RES);
    retire();

    // Back-pressure: result must hold while the consumer stalls and new requests are ignored
    bus.ready_in = 1'b0;
    run_req(4.0, 4'd9, lat);
    chk("bp_lat", 64'(lat), 64'(LAT_OK));
    chk_real("bp_res", res_real(), 0.5, 1e-4);
    held_res     = bus.res_out;
    bus.a_in     = W'(fp_from_real(2.0, F));
    bus.tag_in   = 4'd5;
    bus.valid_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_res_hold",  64'(bus.res_out),   64'(held_res));
    chk("bp_tag_hold",  64'(bus.tag_out),   64'd9);
    chk("bp_ready_low", 64'(bus.ready_out), 64'd0);
    chk("bp_valid_hi",  64'(bus.valid_out), 64'd1);
    chk("bp_err_hold",  64'(bus.err_out),   64'd0);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    retire();
    chk("bp_valid_drop", 64'(bus.valid_out), 64'd0);
    chk("bp_ready_rise", 64'(bus.ready_out), 64'd1);
    chk("bp_idle_res",   64'(bus.res_out),   64'(held_res));
    chk("bp_idle_tag",   64'(bus.tag_out),   64'd9);

    // Back-to-back requests, tags follow results in order
    run_req(1.0, 4'd3, lat);
    chk("b2b_tag3", 64'(bus.tag_out), 64'd3);
    chk_real("b2b_res3", res_real(), 1.0, 1e-4);
    retire();
    run_req(4.0, 4'd7, lat);
    chk("b2b_tag7", 64'(bus.tag_out), 64'd7);
    chk_real("b2b_res7", res_real(), 0.5, 1e-4);
    retire();
    run_req(0.25, 4'd12, lat);
    chk("b2b_tag12", 64'(bus.tag_out), 64'd12);
    chk_real("b2b_res12", res_real(), 2.0, 1e-4);
    retire();
`endif

    // Reset mid-iteration drops the request and clears outputs
    bus.a_in     = W'(fp_from_real(3.0, F));
    bus.tag_in   = 4'd10;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_res",   64'(bus.res_out),   64'd0);
    chk("mid_rst_tag",   64'(bus.tag_out),   64'd0);
    chk("mid_rst_err",   64'(bus.err_out),   64'd0);
    chk("mid_rst_valid", 64'(bus.valid_out), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready_out), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_dropped", 64'(bus.valid_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_inv_sqrt_iter.md
# fp_inv_sqrt_iter

Parametrised, folded fixed-point inverse square root: y = 1/sqrt(a) by Newton–Raphson over a configurable iteration count, sharing one multiplier. Successor to the single-configuration folded unit. Adds a width/format/iteration parameter set, a passthrough tag, an error flag for non-positive input, and output back-pressure. It sits in the ray marcher's vector-normalisation path: the normaliser issues squared lengths and receives reciprocal lengths.

## Interface
- WIDTH, 32, total bits of the signed fixed-point word
- FRAC, 16, fraction bits (Q(WIDTH-FRAC).FRAC)
- ITERS, 4, Newton iterations (1..8)
- TAG_W, 4, tag width carried input→output

- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- a_in  in  WIDTH  signed operand
- tag_in  in  TAG_W  request tag
- valid_in  in  1  request valid
- ready_out  out  1  unit can accept a request
- res_out  out  WIDTH  signed result
- tag_out  out  TAG_W  tag of the result
- err_out  out  1  input was ≤ 0
- valid_out  out  1  result valid
- ready_in  in  1  consumer accepts result

## Operation
- Request handshake: valid_in && ready_out at a rising edge. Capture a_in and tag_in.
- States and transitions:
  - IDLE → SEED on accept.
  - SEED → IT_XY when a > 0; otherwise SEED → DONE.
  - IT_XY → IT_TY → IT_UPD, repeated ITERS times.
  - After the last IT_UPD → DONE.
  - DONE → IDLE on valid_out && ready_in.
- ready_out = 1 only in IDLE. valid_out = 1 only in DONE.
- Seed: p = index of the leading one of a, e = p − FRAC, y0 = 2^(−ceil(e/2)). This guarantees y0·sqrt(a) ∈ [0.707, 1.414).
- Iteration, one multiply per state:
  - t = a·y (IT_XY)
  - t = t·y (IT_TY)
  - y = (y·(3.0 − t)) >>> 1 (IT_UPD)
  - The order keeps every intermediate in range across the full input range.
- Multiply rule: full 2·WIDTH signed product, arithmetic shift right by FRAC, truncate to WIDTH. Constant 3.0 = 3 << FRAC.
- a ≤ 0: res_out = maximum positive value (0 followed by ones), err_out = 1, no iterations run.
- res_out, tag_out and err_out are stable for the whole DONE state and hold their values in IDLE until the next result is written.

## Timing
- Reset values: ready_out = 1 from the first cycle after reset. valid_out, err_out, res_out and tag_out = 0.
- Latency, accept edge to first cycle of valid_out:
  - 2 + 3·ITERS cycles for a > 0 (14 at ITERS = 4)
  - 2 cycles for the error path
- valid_out stays high until ready_in is sampled high. DONE → IDLE on that edge; ready_out rises the following cycle.
- No accept is possible in the same cycle as result retirement.
- Throughput: one request per (3 + 3·ITERS) cycles with ready_in tied high.
- valid_in while ready_out = 0 is ignored. The requester holds the request.
- rst_in mid-operation: next state IDLE. The in-flight result is discarded and all outputs return to reset values.

## Configuration
- FP_INV_SQRT_LUT_SEED_EN:
  - Defined: y0 is the power-of-two seed multiplied by a 16-entry ROM factor. The ROM is indexed by the parity of e and the 3 bits below the leading one, giving initial relative error < 3%. Latency is unchanged. Fewer ITERS are needed: ITERS = 2 meets 1e-4.
  - Undefined: pure power-of-two seed as above, with no ROM inferred.

## Structure
- Shared package holds:
  - the parametrised fixed-point word typedef
  - the state enum (IDLE, SEED, IT_XY, IT_TY, IT_UPD, DONE)
  - the FP_THREE and FP_MAX_POS constant functions
- The codebase's fixed-point helpers (fp_from_real / fp_to_real) are reused by the bench.
- One sub-module: fp_inv_sqrt_seed. It is combinational: leading-one detect, seed exponent, and the optional ROM factor.
- The iteration controller holds:
  - the state register
  - the iteration counter, $clog2(ITERS+1) bits, cleared in SEED and incremented in IT_UPD
  - the y and t registers and the captured operand
  - the single shared multiplier

## Test plan
- Default parameters, ready_in = 1, inputs 0.5, 1.0, 3.7, 6.9: results 1.414214, 1.0, 0.519875, 0.380693, each within 1e-4. valid_out rises exactly 14 cycles after accept.
- Input 2^-16 and 16384.0: results 256.0 and 0.0078125, within 1e-4 relative.
- Input 0 and −2.5: err_out = 1, res_out = 32'h7FFFFFFF, valid_out 2 cycles after accept.
- ready_in held low 5 cycles in DONE: res_out and tag_out stable, ready_out = 0, valid_in ignored. Release → retire, ready_out high the next cycle.
- Back-to-back requests with tags 3, 7, 12: tag_out matches each result in order; reset asserted mid-iteration drops the request and outputs are 0.
- WIDTH = 24, FRAC = 12, ITERS = 2 with FP_INV_SQRT_LUT_SEED_EN defined, input 5.8: 0.415227 within 1e-3, latency 8 cycles.
